// File: rtl/ring_nic.sv
// Network interface between a processing element and the ring router PE port.
// Holds one packet per direction. The processor reaches it through a small register map.
module ring_nic #(
   parameter int DATA_WIDTH = 64,
   parameter int VC_BIT     = 63
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            addr,
   input  logic [DATA_WIDTH-1:0] d_in,
   output logic [DATA_WIDTH-1:0] d_out,
   input  logic                  nicEn,
   input  logic                  nicWrEn,
   output logic                  net_so,
   input  logic                  net_ro,
   output logic [DATA_WIDTH-1:0] net_do,
   input  logic                  net_si,
   output logic                  net_ri,
   input  logic [DATA_WIDTH-1:0] net_di,
   input  logic                  net_polarity
);

   // state | meaning (applies to both in_state and out_state)
   // EMPTY | buffer holds no valid packet
   // FULL  | buffer holds a packet awaiting its consumer
   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} buf_state_t;

   buf_state_t            in_state, in_state_next;
   buf_state_t            out_state, out_state_next;
   logic [DATA_WIDTH-1:0] in_buf, out_buf, read_data;
   logic                  rd_en, rd_in, wr_out, capture;

   assign net_ri = (in_state == EMPTY);
   assign net_do = out_buf;
   assign net_so = (out_state == FULL) & net_ro & (out_buf[VC_BIT] == net_polarity);

   always_comb begin
      rd_en          = nicEn & ~nicWrEn;
      rd_in          = rd_en & (addr == 2'b00);
      wr_out         = nicEn & nicWrEn & (addr == 2'b10) & (out_state == EMPTY);
      capture        = net_si & net_ri;
      in_state_next  = in_state;
      out_state_next = out_state;
      read_data      = '0;

      // capture only happens when EMPTY and the read only clears when FULL, so the two never collide
      if (capture)
         in_state_next = FULL;
      else if (rd_in && in_state == FULL)
         in_state_next = EMPTY;

      if (net_so)
         out_state_next = EMPTY;
      else if (wr_out)
         out_state_next = FULL;

      case (addr)
         2'b00:   read_data = in_buf;
         2'b01:   read_data = DATA_WIDTH'(in_state == FULL);
         2'b11:   read_data = DATA_WIDTH'(out_state == FULL);
         default: read_data = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         in_state  <= EMPTY;
         out_state <= EMPTY;
         in_buf    <= '0;
         out_buf   <= '0;
         d_out     <= '0;
      end else begin
         in_state  <= in_state_next;
         out_state <= out_state_next;
         if (capture)
            in_buf <= net_di;
         if (wr_out)
            out_buf <= d_in;
         if (rd_en)
            d_out <= read_data;
      end
   end

endmodule
